rv32i_dmem_responder: RTL and testbench

- Data-memory responder for the RV32I pipeline core: the target end of the core's load/store request interface.
- Accepts one request at a time through a valid/ready handshake and performs RV32I byte/half/word stores and signed or unsigned loads on an internal word array.
- Returns a response after a programmable wait latency.
- Sits beside the core in the simulation top as its data memory.

---
 rtl/rv32i_dmem_responder_if.sv | 31 +++
 rtl/rv32i_dmem_responder.sv | 159 +++++++++++++++
 tb/tb_rv32i_dmem_responder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_dmem_responder_if.sv
// rv32i_dmem_responder_if
// Load/store request and response bundle between the RV32I core and its data memory.
// master: the core. It drives the request fields and resp_ready.
// slave : the memory responder. It drives req_ready and the response fields.
//   req_valid/req_ready          request handshake
//   req_write, req_funct3        access kind (store/load, RV32I funct3)
//   req_addr, req_wdata          byte address, LSB-aligned store data
//   resp_valid/resp_ready        response handshake
//   resp_rdata, resp_error       extended load data, rejection flag
interface rv32i_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/rv32i_dmem_responder.sv
// rv32i_dmem_responder
// Data memory for the RV32I core. It accepts one request at a time. It performs
// byte/half/word stores and signed or unsigned loads on an internal word array.
// It returns the response LATENCY edges after the request is accepted.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high; memory contents are kept
//   bus    rv32i_dmem_responder_if.slave (request/response handshakes)
module rv32i_dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic clock,
  input  logic reset,
  rv32i_dmem_responder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        cap_write;
  logic [2:0]  cap_f3;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [31:0] rdata_q;
  logic        error_q;

  logic [31:0] mem [DEPTH];

  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] widx;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  illegal;
  logic                  acc_error;
  logic [3:0]            be;
  logic [31:0]           wlane;
  logic [31:0]           rword;
  logic [31:0]           shifted;
  logic [31:0]           load_val;
  logic                  commit;

  // The request is decoded from the captured copy. The bus inputs are ignored after acceptance.
  always_comb begin
    offset       = cap_addr - BASE_ADDR;
    widx         = offset[ADDR_WIDTH+1:2];
    out_of_range = (offset >> (ADDR_WIDTH + 2)) != '0;

    misaligned = 1'b0;
    case (cap_f3[1:0])
      2'b01:   misaligned = cap_addr[0];
      2'b10:   misaligned = cap_addr[1:0] != 2'b00;
      default: misaligned = 1'b0;
    endcase

    if (cap_write)
      illegal = cap_f3[2] || (cap_f3[1:0] == 2'b11);
    else
      illegal = (cap_f3[1:0] == 2'b11) || (cap_f3 == 3'b110);

    acc_error = out_of_range || misaligned || illegal;

    be    = 4'b1111;
    wlane = cap_wdata;
    case (cap_f3[1:0])
      2'b00: begin
        be    = 4'b0001 << cap_addr[1:0];
        wlane = {4{cap_wdata[7:0]}};
      end
      2'b01: begin
        be    = cap_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{cap_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = cap_wdata;
      end
    endcase

    rword   = mem[widx];
    shifted = rword >> {cap_addr[1:0], 3'b000};
    case (cap_f3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = rword;
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = '0;
    endcase

    commit = (state == ST_WAIT) && (cnt == '0);
  end

  // The storage array is never reset. A reset that coincides with the commit edge drops the store.
  always_ff @(posedge clock) begin
    if (!reset && commit && cap_write && !acc_error) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][i*8 +: 8] <= wlane[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_f3    <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            cap_write <= bus.req_write;
            cap_f3    <= bus.req_funct3;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
            cnt       <= LAT_M1;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state   <= ST_RESP;
            error_q <= acc_error;
            rdata_q <= (acc_error || cap_write) ? '0 : load_val;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            state   <= ST_IDLE;
            rdata_q <= '0;
            error_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Reset masks the outputs immediately, before the reset edge clears the state.
  assign bus.req_ready  = !reset && (state == ST_IDLE);
  assign bus.resp_valid = !reset && (state == ST_RESP);
  assign bus.resp_rdata = reset ? '0 : rdata_q;
  assign bus.resp_error = !reset && error_q;

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Self-checking bench for rv32i_dmem_responder. It uses a byte-addressed reference memory.
module tb_rv32i_dmem_responder;

  localparam int unsigned AW   = 10;
  localparam int unsigned LAT  = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MEMBYTES = 4 << AW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rv32i_dmem_responder_if bus ();

  rv32i_dmem_responder #(
    .ADDR_WIDTH(AW),
    .LATENCY(LAT),
    .BASE_ADDR(BASE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int tests  = 0;
  int failed = 0;
  logic [7:0] mbytes [MEMBYTES];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: the RV32I rules applied to a flat byte array.
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    logic [31:0] off;
    int unsigned size;
    logic legal;
    logic [31:0] val;
    off = addr - BASE;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    legal = w ? (f3 <= 3'd2) : (size != 0);
    err = !legal || (off >= 32'(MEMBYTES)) || ((addr % size) != 0);
    rdata = '0;
    if (!err) begin
      if (w) begin
        for (int i = 0; i < int'(size); i++) mbytes[int'(off) + i] = 8'((wdata >> (8 * i)) & 32'hFF);
      end else begin
        val = '0;
        for (int i = 0; i < int'(size); i++) val = val | (32'(mbytes[int'(off) + i]) << (8 * i));
        if (f3 == 3'd0 && val >= 32'h80)   val = val + 32'hFFFF_FF00;
        if (f3 == 3'd1 && val >= 32'h8000) val = val + 32'hFFFF_0000;
        rdata = val;
      end
    end
  endtask

  task automatic start_req(input string tag, input logic w, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clock);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  // Called at the first falling edge after acceptance. It counts edges until resp_valid rises.
  task automatic wait_resp(input string tag, output logic [31:0] rd, output logic er);
    int edges;
    edges = 0;
    check({tag, "_nobusy_ready"}, 32'(bus.req_ready), 32'd0);
    while (edges < 20) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      if (bus.resp_valid) break;
    end
    check({tag, "_latency"}, 32'(edges), 32'(LAT));
    rd = bus.resp_rdata;
    er = bus.resp_error;
  endtask

  task automatic finish_resp(input string tag);
    bus.resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.resp_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_rdata_clr"}, bus.resp_rdata, 32'd0);
  endtask

  task automatic txn(input string tag, input logic w, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rd, output logic er);
    logic [31:0] erd;
    logic eer;
    start_req(tag, w, f3, addr, wdata);
    wait_resp(tag, rd, er);
    model(w, f3, addr, wdata, erd, eer);
    check({tag, "_rdata"}, rd, erd);
    check({tag, "_error"}, 32'(er), 32'(eer));
    finish_resp(tag);
  endtask

  initial begin
    logic [31:0] rd, rd0, erd;
    logic er, er0, eer;
    logic [31:0] a;

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < int'(MEMBYTES); i++) mbytes[i] = 8'h00;

    // Reset for 3 cycles
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_rdata", bus.resp_rdata, 32'd0);
      check("rst_error", 32'(bus.resp_error), 32'd0);
    end
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("idle_ready", 32'(bus.req_ready), 32'd1);
    check("idle_valid", 32'(bus.resp_valid), 32'd0);
    check("idle_rdata", bus.resp_rdata, 32'd0);

    // Define the low 256 bytes so random loads have known contents
    for (int i = 0; i < 64; i++) txn("init", 1'b1, 3'd2, 32'(i * 4), $urandom, rd, er);

    // Word store and load
    txn("sw10", 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, rd, er);
    check("sw10_rd0", rd, 32'd0);
    txn("lw10", 1'b0, 3'd2, 32'h10, 32'h0, rd, er);
    check("lw10_const", rd, 32'hDEAD_BEEF);
    check("lw10_err", 32'(er), 32'd0);

    // Byte enables and extension
    txn("sb11", 1'b1, 3'd0, 32'h11, 32'h0000_00A5, rd, er);
    txn("lw10b", 1'b0, 3'd2, 32'h10, 32'h0, rd, er);
    check("lw10b_const", rd, 32'hDEAD_A5EF);
    txn("lb11", 1'b0, 3'd0, 32'h11, 32'h0, rd, er);
    check("lb11_const", rd, 32'hFFFF_FFA5);
    txn("lbu11", 1'b0, 3'd4, 32'h11, 32'h0, rd, er);
    check("lbu11_const", rd, 32'h0000_00A5);
    txn("lh12", 1'b0, 3'd1, 32'h12, 32'h0, rd, er);
    check("lh12_const", rd, 32'hFFFF_DEAD);
    txn("lhu12", 1'b0, 3'd5, 32'h12, 32'h0, rd, er);
    check("lhu12_const", rd, 32'h0000_DEAD);

    // Error cases
    txn("lw13", 1'b0, 3'd2, 32'h13, 32'h0, rd, er);
    check("lw13_err", 32'(er), 32'd1);
    check("lw13_rd", rd, 32'd0);
    txn("lw20pre", 1'b0, 3'd2, 32'h20, 32'h0, rd0, er);
    txn("sh21", 1'b1, 3'd1, 32'h21, 32'hFFFF_FFFF, rd, er);
    check("sh21_err", 32'(er), 32'd1);
    txn("lw20", 1'b0, 3'd2, 32'h20, 32'h0, rd, er);
    check("lw20_unchanged", rd, rd0);
    txn("lw1000", 1'b0, 3'd2, 32'h1000, 32'h0, rd, er);
    check("lw1000_err", 32'(er), 32'd1);
    check("lw1000_rd", rd, 32'd0);
    txn("ld011", 1'b0, 3'd3, 32'h10, 32'h0, rd, er);
    check("ld011_err", 32'(er), 32'd1);
    check("ld011_rd", rd, 32'd0);

    // Backpressure with a competing request held during RESP
    start_req("bpA", 1'b0, 3'd2, 32'h10, 32'h0);
    wait_resp("bpA", rd, er);
    model(1'b0, 3'd2, 32'h10, 32'h0, erd, eer);
    check("bpA_rdata", rd, erd);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h0;
    repeat (5) begin
      @(posedge clock);
      @(negedge clock);
      check("bp_hold_valid", 32'(bus.resp_valid), 32'd1);
      check("bp_hold_rdata", bus.resp_rdata, rd);
      check("bp_hold_error", 32'(bus.resp_error), 32'(er));
      check("bp_hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.resp_ready = 1'b0;
    check("bp_after_ready", 32'(bus.req_ready), 32'd1);
    check("bp_after_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    wait_resp("bpB", rd, er);
    model(1'b0, 3'd2, 32'h20, 32'h0, erd, eer);
    check("bpB_rdata", rd, erd);
    check("bpB_error", 32'(er), 32'(eer));
    finish_resp("bpB");

    // Reset while a store is waiting to commit
    txn("sw30z", 1'b1, 3'd2, 32'h30, 32'h0, rd, er);
    start_req("sw30", 1'b1, 3'd2, 32'h30, 32'h1234_5678);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clock);
      @(negedge clock);
      check("midrst_ready", 32'(bus.req_ready), 32'd0);
      check("midrst_valid", 32'(bus.resp_valid), 32'd0);
    end
    reset = 1'b0;
    repeat (LAT + 3) begin
      @(posedge clock);
      @(negedge clock);
      check("postrst_novalid", 32'(bus.resp_valid), 32'd0);
    end
    txn("lw30", 1'b0, 3'd2, 32'h30, 32'h0, rd, er);
    check("lw30_const", rd, 32'h0000_0000);

    // Random mix against the reference
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 9) == 0) a = 32'h1000 + $urandom_range(0, 255);
      else a = 32'($urandom_range(0, 255));
      txn("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
